// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types and widths for the continuous monitoring system trace path.
package continuous_monitoring_system_pkg;

  localparam int RISC_V_INSTRUCTION_WIDTH = 32;
  localparam int DEFAULT_PC_WIDTH         = 64;
  localparam int TRACE_ITEM_WIDTH         = DEFAULT_PC_WIDTH + RISC_V_INSTRUCTION_WIDTH;

  typedef struct packed {
    logic [DEFAULT_PC_WIDTH-1:0]         pc;
    logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
  } trace_item_t;

  typedef enum logic {
    EMPTY,
    HOLD
  } packer_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; read data is taken straight from
// the storage array so a word is presented in the cycle after it is written.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  // Full is judged before any same-cycle pop, so a push into a full FIFO is refused.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers define validity and pop_data is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/trace_packer.sv
// Stages accepted trace items one deep, frames them into packets (size, idle
// timeout, flush) and buffers {tlast, pc, instr} for an AXI-Stream master.
module trace_packer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int PC_WIDTH     = DEFAULT_PC_WIDTH,
  parameter int FIFO_DEPTH   = 16,
  parameter int PACKET_ITEMS = 8,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  input  logic [PC_WIDTH-1:0]                          in_pc,
  input  logic [RISC_V_INSTRUCTION_WIDTH-1:0]          in_instr,
  input  logic                                         in_drop,
  input  logic                                         flush,
  output logic [PC_WIDTH+RISC_V_INSTRUCTION_WIDTH-1:0] m_tdata,
  output logic                                         m_tvalid,
  output logic                                         m_tlast,
  input  logic                                         m_tready,
  output logic [31:0]                                  overflow_count
);

  localparam int          IW       = PC_WIDTH + RISC_V_INSTRUCTION_WIDTH;
  localparam logic [7:0]  LAST_CNT = 8'(PACKET_ITEMS - 1);
  localparam logic [16:0] TIMEOUT  = 17'(IDLE_TIMEOUT);

  packer_state_e state;
  logic [IW-1:0] stage_data;
  logic [7:0]    pkt_cnt;
  logic [15:0]   idle_cnt;
  logic          close_pending;

  logic          accept;
  logic          timeout;
  logic          close_req;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          push_last;
  logic [IW:0]   fifo_rd;

  assign accept    = in_valid && !in_drop;
  // Compare against the incremented count so the close lands on the edge the
  // counter would reach IDLE_TIMEOUT.
  assign timeout   = (({1'b0, idle_cnt} + 17'd1) == TIMEOUT);
  assign close_req = flush || close_pending || timeout;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    if (state == HOLD && !fifo_full) begin
      if (accept) begin
        push      = 1'b1;
        push_last = flush || close_pending || (pkt_cnt == LAST_CNT);
      end else if (close_req) begin
        push      = 1'b1;
        push_last = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= EMPTY;
      stage_data     <= '0;
      pkt_cnt        <= '0;
      idle_cnt       <= '0;
      close_pending  <= 1'b0;
      overflow_count <= '0;
    end else begin
      if (push) pkt_cnt <= push_last ? 8'd0 : pkt_cnt + 8'd1;

      unique case (state)
        EMPTY: begin
          if (accept) begin
            stage_data    <= {in_pc, in_instr};
            idle_cnt      <= '0;
            close_pending <= 1'b0;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (!fifo_full) begin
            if (accept) begin
              stage_data    <= {in_pc, in_instr};
              idle_cnt      <= '0;
              close_pending <= 1'b0;
            end else if (close_req) begin
              close_pending <= 1'b0;
              state         <= EMPTY;
            end else begin
              idle_cnt <= idle_cnt + 16'd1;
            end
          end else begin
            // No room: the newcomer is lost and any close waits for a free slot.
            if (accept && overflow_count != '1) overflow_count <= overflow_count + 32'd1;
            if (close_req) close_pending <= 1'b1;
            else           idle_cnt      <= idle_cnt + 16'd1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (IW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({push_last, stage_data}),
    .full      (fifo_full),
    .pop       (m_tready),
    .pop_data  (fifo_rd),
    .empty     (fifo_empty)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tlast  = fifo_rd[IW];
  assign m_tdata  = fifo_rd[IW-1:0];

endmodule

// File: doc/trace_packer.md
# trace_packer

Downstream stage of the trace filter. Captures every trace item that the filter does not drop, frames the items into packets and buffers them in a FIFO. The buffered items leave on an AXI-Stream master that feeds the host DMA path. A one-item staging register holds back the newest item so that `tlast` can be decided correctly at packet size, on idle timeout or on explicit flush.

## Interface
Parameters:
- `PC_WIDTH`, 64: program counter width.
- `FIFO_DEPTH`, 16: FIFO entries. Must be a power of 2 and at least 2.
- `PACKET_ITEMS`, 8: maximum items per packet. Range 1..255.
- `IDLE_TIMEOUT`, 64: cycles a staged item may wait before it is closed as packet end. Range 1..65535.

Ports (reset rst_n, synchronous, active-low; clock clk):
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `in_valid`  in  1  a trace item is present this cycle. It is aligned with `in_drop`, i.e. `pc_valid` delayed one cycle by the integration.
- `in_pc`  in  PC_WIDTH  PC of the item.
- `in_instr`  in  RISC_V_INSTRUCTION_WIDTH  instruction of the item.
- `in_drop`  in  1  filter verdict. 1 discards the item.
- `flush`  in  1  single-cycle pulse that closes the open packet.
- `m_tdata`  out  PC_WIDTH+RISC_V_INSTRUCTION_WIDTH  {pc, instr}, with pc in the MSBs.
- `m_tvalid`  out  1  FIFO not empty.
- `m_tlast`  out  1  current word ends a packet.
- `m_tready`  in  1  consumer accepts the word.
- `overflow_count`  out  32  saturating count of lost items.

## Operation
- An item is accepted when `in_valid && !in_drop`. Items with `in_drop=1` have no effect at all.
- Staging FSM states:
  - EMPTY: no item staged. An accepted item is written to the staging register → HOLD; the idle counter is cleared.
  - HOLD, accepted item arrives:
    - FIFO not full: push the staged item with `tlast = (pkt_cnt == PACKET_ITEMS-1)`, stage the new item, clear the idle counter. Stay in HOLD.
    - FIFO full: the new item is lost and `overflow_count` is incremented. The staged item is kept and the idle counter keeps running.
  - HOLD, no accepted item: the idle counter increments. When `flush` is high or the idle counter equals IDLE_TIMEOUT, push the staged item with `tlast=1` → EMPTY. If the FIFO is full, the close stays pending (flag latched, the idle counter stops incrementing) until a slot frees.
- `flush` arriving in the same cycle as an accepted item: the staged item (if any) is pushed with `tlast=1` and the new item is staged, so the new item starts a new packet. With the FIFO full, the new item is lost and the close stays pending.
- `flush` in EMPTY: no effect. Empty packets are never produced.
- `pkt_cnt` (8-bit) increments on every push and returns to 0 on any push with `tlast=1`.
- FIFO entry = {tlast, pc, instr}.
  - Pop on `m_tvalid && m_tready`.
  - Push and pop are allowed in the same cycle. "Full" is evaluated before the pop, so a push is refused while full even if a pop happens in that cycle.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- `overflow_count` saturates at 2^32-1. It clears only on reset.

## Timing
- Reset values: `m_tvalid=0`, `m_tlast=0`, `m_tdata=0`, `overflow_count=0`, FSM=EMPTY, all pointers and counters 0. Reset in the middle of a packet discards the staged item and the FIFO contents.
- The staging register and the FIFO write are both updated on the clock edge that samples the event.
- Latency from item accept to appearance on `m_tvalid`:
  - 2 cycles minimum when the next item follows on the next cycle.
  - IDLE_TIMEOUT+1 cycles for the final item of a burst.
- AXI-Stream rules:
  - `m_tdata` and `m_tlast` are stable while `m_tvalid && !m_tready`.
  - `m_tvalid` does not depend combinationally on `m_tready`.
  - Read data comes straight from registered FIFO memory with no bubble, giving one word per cycle sustained.

## Structure
- Into `continuous_monitoring_system_pkg`:
  - `PC_WIDTH` default.
  - `TRACE_ITEM_WIDTH` = PC_WIDTH + RISC_V_INSTRUCTION_WIDTH.
  - `trace_item_t` packed struct {pc, instr}.
  - `packer_state_e` enum {EMPTY, HOLD}.
- One sub-module, `sync_fifo`: parameterised width and depth, with push/pop/full/empty. It is reusable elsewhere in the monitoring system.

## Test plan
- PACKET_ITEMS=4, 10 accepted items back-to-back, `m_tready=1`, idle afterwards → 10 words in order, `tlast` on words 4, 8 and 10. Word 10 appears IDLE_TIMEOUT+1 cycles after its acceptance.
- Alternating `in_drop`=1/0 over 8 valid cycles → only the 4 undropped items appear, `overflow_count=0`.
- `flush` pulse in the same cycle as the 3rd item of a packet → item 2 has `tlast=1` and item 3 starts a new packet. A `flush` in EMPTY produces no word.
- FIFO_DEPTH=4, `m_tready=0`, 8 accepted items back-to-back → the 4 items that reach the FIFO are items 1–4 and item 5 sits in staging. Items 6–8 are lost, so `overflow_count=3`. Raising `m_tready` then releases items 1–5, with item 5 carrying `tlast` after the timeout.
- Backpressure: toggle `m_tready` randomly for 200 items → no loss, order and tlast positions match the model, `m_tdata` stays stable during stalls.
- Reset asserted with 3 words queued and 1 staged → the next cycle shows `m_tvalid=0` and `overflow_count=0`, and the first post-reset item starts a packet with `pkt_cnt=0`.
